// File: rtl/vtg_pkg.sv
// Shared types and timing helpers for the video timing generator.
package vtg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int axis_total(input int display, input int front, input int sync, input int back);
        return display + front + sync + back;
    endfunction

    function automatic int sync_start(input int display, input int front);
        return display + front;
    endfunction

    function automatic int sync_end(input int display, input int front, input int sync);
        return display + front + sync - 1;
    endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: position counter plus registered sync/active decode of the next position.
module vtg_axis_counter
    import vtg_pkg::*;
#(
    parameter int DISPLAY = 800,
    parameter int FRONT   = 56,
    parameter int SYNC    = 120,
    parameter int BACK    = 64,
    parameter int POL     = 1,
    parameter int CNT_W   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] pos,
    output logic             wrap,
    output logic             sync,
    output logic             active
);

    localparam int TOTAL = axis_total(DISPLAY, FRONT, SYNC, BACK);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] S_START  = CNT_W'(sync_start(DISPLAY, FRONT));
    localparam logic [CNT_W-1:0] S_END    = CNT_W'(sync_end(DISPLAY, FRONT, SYNC));
    localparam logic [CNT_W-1:0] DISP_END = CNT_W'(DISPLAY);
    localparam logic             ACT      = (POL != 0);

    logic [CNT_W-1:0] pos_next;
    logic             at_last;

    assign at_last = (pos == LAST);
    assign wrap    = inc && at_last;

    always_comb begin
        pos_next = pos;
        if (clr)
            pos_next = '0;
        else if (inc)
            pos_next = at_last ? '0 : pos + CNT_W'(1);
    end

    // Decode is taken from pos_next so the flags line up with pos on the same cycle;
    // clr forces the blanked (idle) levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos    <= '0;
            sync   <= ~ACT;
            active <= 1'b0;
        end else if (ce) begin
            pos    <= pos_next;
            sync   <= (!clr && pos_next >= S_START && pos_next <= S_END) ? ACT : ~ACT;
            active <= !clr && (pos_next < DISP_END);
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with run/stop handshake (stop completes the frame).
// Optional VTG_PREFETCH_EN adds one-step-ahead position outputs.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int H_DISPLAY = 800,
    parameter int H_FRONT   = 56,
    parameter int H_SYNC    = 120,
    parameter int H_BACK    = 64,
    parameter int V_DISPLAY = 600,
    parameter int V_FRONT   = 37,
    parameter int V_SYNC    = 6,
    parameter int V_BACK    = 23,
    parameter int H_POL     = 1,
    parameter int V_POL     = 1,
    parameter int CNT_W     = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             run,
    output logic             busy,
    output logic [CNT_W-1:0] hpos,
    output logic [CNT_W-1:0] vpos,
    output logic             hsync,
    output logic             vsync,
    output logic             display_on,
    output logic             line_start,
    output logic             frame_start
`ifdef VTG_PREFETCH_EN
    ,
    output logic [CNT_W-1:0] nxt_hpos,
    output logic [CNT_W-1:0] nxt_vpos,
    output logic             nxt_display_on
`endif
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK) - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK) - 1);

    state_t state_reg, state_next;
    logic   frame_last;
    logic   cnt_clr, h_inc, h_wrap, v_wrap;
    logic   h_active, v_active;

    assign frame_last = (hpos == H_LAST) && (vpos == V_LAST);

    // A stop request seen on the last pixel of a frame halts right there, whether
    // or not the FSM had already entered DRAIN.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (run) state_next = RUN;
            RUN:     if (!run) state_next = frame_last ? IDLE : DRAIN;
            DRAIN:   if (run) state_next = RUN;
                     else if (frame_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Leaving IDLE presents (0,0) without incrementing.
    assign cnt_clr = (state_next == IDLE);
    assign h_inc   = (state_reg != IDLE);

    vtg_axis_counter #(
        .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
        .POL(H_POL), .CNT_W(CNT_W)
    ) u_h_axis (
        .clk(clk), .rst(rst), .ce(ce), .clr(cnt_clr), .inc(h_inc),
        .pos(hpos), .wrap(h_wrap), .sync(hsync), .active(h_active)
    );

    vtg_axis_counter #(
        .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
        .POL(V_POL), .CNT_W(CNT_W)
    ) u_v_axis (
        .clk(clk), .rst(rst), .ce(ce), .clr(cnt_clr), .inc(h_wrap),
        .pos(vpos), .wrap(v_wrap), .sync(vsync), .active(v_active)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            busy        <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            state_reg   <= state_next;
            busy        <= (state_next != IDLE);
            line_start  <= (state_next != IDLE) && ((state_reg == IDLE) || h_wrap);
            frame_start <= (state_next != IDLE) && ((state_reg == IDLE) || v_wrap);
        end
    end

    // Both axis flags are registered and forced low while idle.
    assign display_on = h_active && v_active;

`ifdef VTG_PREFETCH_EN
    localparam logic [CNT_W-1:0] H_DISP_END = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_DISP_END = CNT_W'(V_DISPLAY);

    always_comb begin
        nxt_hpos = '0;
        nxt_vpos = '0;
        if (busy) begin
            nxt_hpos = (hpos == H_LAST) ? '0 : hpos + CNT_W'(1);
            nxt_vpos = vpos;
            if (hpos == H_LAST)
                nxt_vpos = (vpos == V_LAST) ? '0 : vpos + CNT_W'(1);
        end
    end

    assign nxt_display_on = busy && (nxt_hpos < H_DISP_END) && (nxt_vpos < V_DISP_END);
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen (small 16x8 raster); covers VTG_PREFETCH_EN when defined.
module tb_video_timing_gen;

    localparam int HT = 16;
    localparam int VT = 8;
    localparam int FRAME = HT * VT;
    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ce  = 1'b0;
    logic         run = 1'b0;
    logic         busy;
    logic [W-1:0] hpos, vpos;
    logic         hsync, vsync, display_on, line_start, frame_start;
`ifdef VTG_PREFETCH_EN
    logic [W-1:0] nxt_hpos, nxt_vpos;
    logic         nxt_display_on;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: a running flag and a linear pixel index within the frame.
    bit m_run = 1'b0;
    int m_p   = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_POL(1), .V_POL(0), .CNT_W(W)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .run(run), .busy(busy),
        .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
        .display_on(display_on), .line_start(line_start), .frame_start(frame_start)
`ifdef VTG_PREFETCH_EN
        , .nxt_hpos(nxt_hpos), .nxt_vpos(nxt_vpos), .nxt_display_on(nxt_display_on)
`endif
    );

    function automatic logic [15:0] dut_vec();
        return {busy, hpos, vpos, hsync, vsync, display_on, line_start, frame_start};
    endfunction

    function automatic logic [15:0] exp_vec();
        int h, v;
        logic [W-1:0] hh, vv;
        h = m_p % HT;
        v = m_p / HT;
        if (!m_run)
            return {1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        hh = W'(h);
        vv = W'(v);
        return {1'b1, hh, vv, (h >= 10 && h <= 12), !(v >= 5 && v <= 6),
                (h < 8 && v < 4), (h == 0), (m_p == 0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void model_step(input bit c, input bit r);
        if (!c) return;
        if (!m_run) begin
            if (r) begin
                m_run = 1'b1;
                m_p   = 0;
            end
        end else if (!r && m_p == FRAME - 1) begin
            m_run = 1'b0;
            m_p   = 0;
        end else begin
            m_p = (m_p + 1) % FRAME;
        end
    endfunction

    // Inputs change at negedge; outputs are checked at the following negedge.
    task automatic step(input bit c, input bit r, input string name);
        ce  = c;
        run = r;
        @(posedge clk);
        model_step(c, r);
        @(negedge clk);
        check(name, 32'(dut_vec()), 32'(exp_vec()));
    endtask

    task automatic goto_pos(input int target, input bit r, input string name);
        int n;
        n = 0;
        while (!(m_run && m_p == target) && n < 400) begin
            step(1'b1, r, name);
            n++;
        end
        check({name, "_reached"}, 32'(m_p), 32'(target));
    endtask

    typedef struct {
        bit         c;
        bit         r;
        logic       busy;
        logic [4:0] h;
        logic [4:0] v;
        logic       ls;
        logic       fs;
        logic       disp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int fs_cycles[$];
        int cyc, ls_clocks, n, stop_ok, fs_after;
        logic [9:0] prev_pos;

        tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 1, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{1, 1, 1, 0, 0, 1, 1, 1};
        tbl[3] = '{0, 0, 1, 0, 0, 1, 1, 1};
        tbl[4] = '{1, 1, 1, 1, 0, 0, 0, 1};
        tbl[5] = '{1, 1, 1, 2, 0, 0, 0, 1};
        tbl[6] = '{0, 1, 1, 2, 0, 0, 0, 1};
        tbl[7] = '{1, 1, 1, 3, 0, 0, 0, 1};

        // Reset state while rst is held
        @(negedge clk);
        @(negedge clk);
        check("reset_state", 32'(dut_vec()), 32'(exp_vec()));
        rst = 1'b0;
        $display("[TB] reset released");

        // Table: start-up, ce gating and strobe holding
        for (int i = 0; i < 8; i++) begin
            ce  = tbl[i].c;
            run = tbl[i].r;
            @(posedge clk);
            model_step(tbl[i].c, tbl[i].r);
            @(negedge clk);
            check($sformatf("table_%0d", i),
                  32'({busy, hpos, vpos, line_start, frame_start, display_on}),
                  32'({tbl[i].busy, tbl[i].h, tbl[i].v, tbl[i].ls, tbl[i].fs, tbl[i].disp}));
            $display("[TB] table %0d ce=%0d run=%0d -> busy=%0d pos=(%0d,%0d)", i,
                     tbl[i].c, tbl[i].r, busy, hpos, vpos);
        end

        // ce toggling: line_start stays high across the held clock
        goto_pos(HT - 1, 1'b1, "to_line_end");
        ls_clocks = 0;
        for (int i = 0; i < 4; i++) begin
            step(i[0] == 1'b0, 1'b1, "ce_toggle");
            if (line_start) ls_clocks++;
        end
        check("line_start_width", 32'(ls_clocks), 32'd2);
        $display("[TB] ce toggle: line_start high for %0d clocks", ls_clocks);

        // Steady run: frame_start period
        for (cyc = 0; cyc < 3 * FRAME; cyc++) begin
            step(1'b1, 1'b1, "steady");
            if (frame_start) fs_cycles.push_back(cyc);
        end
        check("fs_count", 32'(fs_cycles.size()), 32'd3);
        for (int i = 1; i < fs_cycles.size(); i++)
            check("fs_period", 32'(fs_cycles[i] - fs_cycles[i-1]), 32'(FRAME));
        $display("[TB] steady run: %0d frame starts", fs_cycles.size());

        // Stop request at (5,2): frame completes, then idle
        goto_pos(2 * HT + 5, 1'b1, "to_5_2");
        n = 0;
        prev_pos = {hpos, vpos};
        while (busy && n < 2 * FRAME) begin
            prev_pos = {hpos, vpos};
            step(1'b1, 1'b0, "drain");
            n++;
        end
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_after_last", 32'(prev_pos), 32'({5'd15, 5'd7}));
        fs_after = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, "idle_hold");
            if (frame_start) fs_after++;
        end
        check("no_fs_idle", 32'(fs_after), 32'd0);
        $display("[TB] drain stop after (%0d,%0d)", prev_pos[9:5], prev_pos[4:0]);

        // Stop request withdrawn at (3,6): no gap into the next frame
        step(1'b1, 1'b1, "restart");
        goto_pos(2 * HT + 5, 1'b1, "to_5_2b");
        goto_pos(6 * HT + 3, 1'b0, "to_3_6");
        n = 0;
        stop_ok = 1;
        do begin
            step(1'b1, 1'b1, "reraise");
            n++;
            if (!busy) stop_ok = 0;
        end while (!frame_start && n < 2 * FRAME);
        check("reraise_gap", 32'(n), 32'(FRAME - (6 * HT + 3)));
        check("reraise_busy", 32'(stop_ok), 32'd1);
        $display("[TB] re-raise: frame_start after %0d steps", n);

        // Randomised ce/run against the model
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) != 0, "random");
        $display("[TB] random phase done");

`ifdef VTG_PREFETCH_EN
        goto_pos(3 * HT + 15, 1'b1, "to_15_3");
        check("prefetch_15_3", 32'({nxt_hpos, nxt_vpos, nxt_display_on}),
              32'({5'd0, 5'd4, 1'b0}));
        goto_pos(1 * HT + 6, 1'b1, "to_6_1");
        check("prefetch_6_1", 32'({nxt_hpos, nxt_vpos, nxt_display_on}),
              32'({5'd7, 5'd1, 1'b1}));
`endif

        // Asynchronous reset mid-frame
        goto_pos(50, 1'b1, "to_mid");
        ce = 1'b1;
        run = 1'b1;
        #2 rst = 1'b1;
        #1;
        m_run = 1'b0;
        m_p   = 0;
        check("async_reset", 32'(dut_vec()), 32'(exp_vec()));
        @(negedge clk);
        check("reset_held", 32'(dut_vec()), 32'(exp_vec()));
`ifdef VTG_PREFETCH_EN
        check("prefetch_idle", 32'({nxt_hpos, nxt_vpos, nxt_display_on}), 32'd0);
`endif
        run = 1'b0;
        rst = 1'b0;
        step(1'b1, 1'b0, "post_reset_idle");
        step(1'b1, 1'b1, "post_reset_start");
        $display("[TB] mid-frame reset done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
